masked_thermostat_seq: RTL and testbench

//  Sequencer for the first-order 2-share (DOM) thermostat datapath.

---
 rtl/masked_thermostat_seq.sv | 211 +++++++++++++++++++++
 tb/tb_masked_thermostat_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/masked_thermostat_seq.sv
// Sequencer and 2-share DOM datapath for the masked thermostat (heater/aircon/fan).
// Optional build macro SHARE_CLEAR_EN adds a CLEAR state that wipes all share registers after each result.
module masked_thermostat_seq #(
    parameter int unsigned RND_TIMEOUT = 255,
    parameter int unsigned EVAL_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  too_cold0,
    input  logic                  too_cold1,
    input  logic                  too_hot0,
    input  logic                  too_hot1,
    input  logic                  mode0,
    input  logic                  mode1,
    input  logic                  fan_on0,
    input  logic                  fan_on1,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    input  logic [3:0]            rnd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  heater0,
    output logic                  heater1,
    output logic                  aircon0,
    output logic                  aircon1,
    output logic                  fan0,
    output logic                  fan1,
    output logic                  rnd_err,
    output logic [EVAL_CNT_W-1:0] eval_cnt
);

    localparam int unsigned TO_W = 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RND_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RND, S_L1, S_L2, S_L3, S_OUT, S_CLEAR
    } state_t;

    state_t state_q, state_d;
    logic   cap_in, cap_rnd, abort, ld_l2, ld_l3, ld_out, done, clr;

    logic [TO_W-1:0]       to_cnt_q;
    logic                  in_ready_q, rnd_ready_q, out_valid_q, rnd_err_q;
    logic [EVAL_CNT_W-1:0] eval_cnt_q;

    // Share registers, index = share number
    logic [1:0] mode_q, cold_q, hot_q, fan_on_q;
    logic [3:0] rnd_q;
    logic [1:0] heat_t_q, heat_x_q, air_t_q, air_x_q;
    logic [1:0] fo_l_q, fo_t_q, fo_x_q;
    logic [1:0] fan_l_q, fan_t_q, fan_x_q;
    logic [1:0] heat_o_q, air_o_q, fan_o_q;

    // Share-local recombination of registered DOM terms
    logic [1:0] nmode, heat_s, air_s, fo_s, fan_s;

    always_comb begin
        nmode  = {mode_q[1], ~mode_q[0]};
        heat_s = heat_t_q ^ heat_x_q;
        air_s  = air_t_q ^ air_x_q;
        fo_s   = fo_l_q ^ fo_t_q ^ fo_x_q;
        fan_s  = fan_l_q ^ fan_t_q ^ fan_x_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cap_in  = 1'b0;
        cap_rnd = 1'b0;
        abort   = 1'b0;
        ld_l2   = 1'b0;
        ld_l3   = 1'b0;
        ld_out  = 1'b0;
        done    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid) begin
                cap_in  = 1'b1;
                state_d = S_RND;
            end
            S_RND: begin
                if (rnd_valid) begin
                    cap_rnd = 1'b1;
                    state_d = S_L1;
                end else if (to_cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_L1: begin
                ld_l2   = 1'b1;
                state_d = S_L2;
            end
            S_L2: begin
                ld_l3   = 1'b1;
                state_d = S_L3;
            end
            S_L3: begin
                ld_out  = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: if (out_ready) begin
                done = 1'b1;
`ifdef SHARE_CLEAR_EN
                clr     = 1'b1;
                state_d = S_CLEAR;
`else
                state_d = S_IDLE;
`endif
            end
            S_CLEAR: begin
                clr     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake, status and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            rnd_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            rnd_err_q   <= 1'b0;
            eval_cnt_q  <= '0;
        end else begin
            to_cnt_q    <= (state_q == S_RND && state_d == S_RND) ? to_cnt_q + TO_W'(1) : '0;
            in_ready_q  <= (state_d == S_IDLE);
            rnd_ready_q <= (state_d == S_RND);
            out_valid_q <= (state_d == S_OUT);
            rnd_err_q   <= abort;
            if (done) eval_cnt_q <= eval_cnt_q + EVAL_CNT_W'(1);
        end
    end

    // DOM datapath: one register layer per gadget, cross terms kept separate until after the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0; cold_q <= '0; hot_q <= '0; fan_on_q <= '0;
            rnd_q <= '0;
            heat_t_q <= '0; heat_x_q <= '0; air_t_q <= '0; air_x_q <= '0;
            fo_l_q <= '0; fo_t_q <= '0; fo_x_q <= '0;
            fan_l_q <= '0; fan_t_q <= '0; fan_x_q <= '0;
            heat_o_q <= '0; air_o_q <= '0; fan_o_q <= '0;
        end else if (clr) begin
            mode_q <= '0; cold_q <= '0; hot_q <= '0; fan_on_q <= '0;
            rnd_q <= '0;
            heat_t_q <= '0; heat_x_q <= '0; air_t_q <= '0; air_x_q <= '0;
            fo_l_q <= '0; fo_t_q <= '0; fo_x_q <= '0;
            fan_l_q <= '0; fan_t_q <= '0; fan_x_q <= '0;
            heat_o_q <= '0; air_o_q <= '0; fan_o_q <= '0;
        end else begin
            if (cap_in) begin
                mode_q   <= {mode1, mode0};
                cold_q   <= {too_cold1, too_cold0};
                hot_q    <= {too_hot1, too_hot0};
                fan_on_q <= {fan_on1, fan_on0};
            end
            if (abort) begin
                mode_q <= '0; cold_q <= '0; hot_q <= '0; fan_on_q <= '0;
            end
            if (cap_rnd) begin
                rnd_q       <= rnd_data;
                heat_t_q    <= mode_q & cold_q;
                heat_x_q[0] <= (mode_q[0] & cold_q[1]) ^ rnd_data[0];
                heat_x_q[1] <= (mode_q[1] & cold_q[0]) ^ rnd_data[0];
                air_t_q     <= nmode & hot_q;
                air_x_q[0]  <= (nmode[0] & hot_q[1]) ^ rnd_data[1];
                air_x_q[1]  <= (nmode[1] & hot_q[0]) ^ rnd_data[1];
            end
            if (ld_l2) begin
                fo_l_q    <= fan_on_q ^ heat_s;
                fo_t_q    <= fan_on_q & heat_s;
                fo_x_q[0] <= (fan_on_q[0] & heat_s[1]) ^ rnd_q[2];
                fo_x_q[1] <= (fan_on_q[1] & heat_s[0]) ^ rnd_q[2];
            end
            if (ld_l3) begin
                fan_l_q    <= fo_s ^ air_s;
                fan_t_q    <= fo_s & air_s;
                fan_x_q[0] <= (fo_s[0] & air_s[1]) ^ rnd_q[3];
                fan_x_q[1] <= (fo_s[1] & air_s[0]) ^ rnd_q[3];
            end
            if (ld_out) begin
                heat_o_q <= heat_s;
                air_o_q  <= air_s;
                fan_o_q  <= fan_s;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign rnd_ready = rnd_ready_q;
    assign out_valid = out_valid_q;
    assign rnd_err   = rnd_err_q;
    assign eval_cnt  = eval_cnt_q;
    assign heater0   = heat_o_q[0];
    assign heater1   = heat_o_q[1];
    assign aircon0   = air_o_q[0];
    assign aircon1   = air_o_q[1];
    assign fan0      = fan_o_q[0];
    assign fan1      = fan_o_q[1];

endmodule

// File: tb/tb_masked_thermostat_seq.sv
// Scoreboard bench for masked_thermostat_seq: stimulus pushes expected unmasked results, a monitor pops on each output handshake.
module tb_masked_thermostat_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        too_cold0, too_cold1, too_hot0, too_hot1;
    logic        mode0, mode1, fan_on0, fan_on1;
    logic        rnd_valid, rnd_ready;
    logic [3:0]  rnd_data;
    logic        out_valid, out_ready;
    logic        heater0, heater1, aircon0, aircon1, fan0, fan1;
    logic        rnd_err;
    logic [15:0] eval_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  exp_q[$];

    masked_thermostat_seq #(.RND_TIMEOUT(8), .EVAL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .too_cold0(too_cold0), .too_cold1(too_cold1),
        .too_hot0(too_hot0), .too_hot1(too_hot1),
        .mode0(mode0), .mode1(mode1),
        .fan_on0(fan_on0), .fan_on1(fan_on1),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .heater0(heater0), .heater1(heater1),
        .aircon0(aircon0), .aircon1(aircon1),
        .fan0(fan0), .fan1(fan1),
        .rnd_err(rnd_err), .eval_cnt(eval_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare recombined output shares whenever the output handshake fires
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: unexpected output %b", {heater0 ^ heater1, aircon0 ^ aircon1, fan0 ^ fan1});
            end else begin
                logic [2:0] e;
                logic [2:0] g;
                e = exp_q.pop_front();
                g = {heater0 ^ heater1, aircon0 ^ aircon1, fan0 ^ fan1};
                if (g !== e) begin
                    n_err++;
                    $display("FAIL scoreboard: got h/a/f %b expected %b", g, e);
                end
            end
        end
        if (rst_n && in_ready && rnd_ready) begin
            n_err++;
            $display("FAIL ready_excl: in_ready and rnd_ready both high");
        end
    end

    // Present one input share set and wait for it to be accepted
    task automatic send_in(input logic m, input logic c, input logic h, input logic f, input logic [3:0] msk);
        logic ht, ac;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        mode0 = m ^ msk[0];     mode1 = msk[0];
        too_cold0 = c ^ msk[1]; too_cold1 = msk[1];
        too_hot0 = h ^ msk[2];  too_hot1 = msk[2];
        fan_on0 = f ^ msk[3];   fan_on1 = msk[3];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        ht = m & c;
        ac = ~m & h;
        exp_q.push_back({ht, ac, f | ht | ac});
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_wait", 32'(out_valid), 32'd1);
    endtask

    // Full evaluation with PRNG word ready and consumer ready; lat counts edges from input accept to out_valid
    task automatic run_eval(input logic m, input logic c, input logic h, input logic f,
                            input logic [3:0] msk, input logic [3:0] rnd, output int lat);
        rnd_valid = 1'b1;
        rnd_data  = rnd;
        send_in(m, c, h, f, msk);
        wait_out(lat);
        rnd_valid = 1'b0;
        tick();
    endtask

    initial begin
        int         lat;
        int         k;
        logic       saw_ov;
        logic       stable;
        logic [5:0] snap;

        rst_n = 1'b0;
        in_valid = 1'b0;
        {too_cold0, too_cold1, too_hot0, too_hot1, mode0, mode1, fan_on0, fan_on1} = '0;
        rnd_valid = 1'b0;
        rnd_data = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_outputs", {26'd0, rnd_ready, out_valid, rnd_err, 3'd0}, 32'd0);
        check("reset_shares", 32'({heater0, heater1, aircon0, aircon1, fan0, fan1}), 32'd0);
        check("reset_eval_cnt", 32'(eval_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed first vector, latency from input accept
        run_eval(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'b1010, lat);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_eval_cnt", 32'(eval_cnt), 32'd1);

        // All 16 unmasked combinations from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            run_eval(v[3], v[2], v[1], v[0], 4'($urandom), 4'($urandom), lat);
        end
        check("t2_eval_cnt", 32'(eval_cnt), 32'd16);

        // PRNG timeout
        rnd_valid = 1'b0;
        send_in(1'b1, 1'b0, 1'b1, 1'b1, 4'h5);
        void'(exp_q.pop_back());
        k = 0;
        saw_ov = 1'b0;
        while (!rnd_err && k < 20) begin
            tick();
            k++;
            if (out_valid) saw_ov = 1'b1;
        end
        check("t3_err_delay", 32'(k), 32'd8);
        check("t3_idle", 32'(in_ready), 32'd1);
        tick();
        check("t3_err_pulse", 32'(rnd_err), 32'd0);
        check("t3_no_out_valid", 32'(saw_ov), 32'd0);
        check("t3_eval_cnt", 32'(eval_cnt), 32'd16);

        // Back-pressure in OUT
        rnd_valid = 1'b1;
        rnd_data  = 4'b0110;
        out_ready = 1'b0;
        send_in(1'b0, 1'b0, 1'b1, 1'b0, 4'h9);
        wait_out(lat);
        rnd_valid = 1'b0;
        snap = {heater0, heater1, aircon0, aircon1, fan0, fan1};
        in_valid = 1'b1;
        mode0 = ~mode0;
        too_cold0 = ~too_cold0;
        stable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            if ({heater0, heater1, aircon0, aircon1, fan0, fan1} !== snap || in_ready || !out_valid) stable = 1'b0;
        end
        check("t4_hold_stable", 32'(stable), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_release_in_ready", 32'(in_ready), 32'd1);
        check("t4_release_out_valid", 32'(out_valid), 32'd0);
        check("t4_eval_cnt", 32'(eval_cnt), 32'd17);

        // Reset while in L2
        rnd_valid = 1'b1;
        rnd_data  = 4'b1111;
        send_in(1'b1, 1'b1, 1'b1, 1'b1, 4'h3);
        tick();
        tick();
        rnd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check("t5_rst_outputs", {23'd0, rnd_ready, out_valid, rnd_err, heater0, heater1, aircon0, aircon1, fan0, fan1}, 32'd0);
        check("t5_rst_eval_cnt", 32'(eval_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_eval(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'b0101, lat);
        check("t5_post_latency", 32'(lat), 32'd5);
        check("t5_post_eval_cnt", 32'(eval_cnt), 32'd1);

`ifdef SHARE_CLEAR_EN
        // Share clearing after the output handshake
        rnd_valid = 1'b1;
        rnd_data  = 4'b0011;
        out_ready = 1'b0;
        send_in(1'b1, 1'b1, 1'b0, 1'b1, 4'h6);
        wait_out(lat);
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t6_shares_zero", 32'({heater0, heater1, aircon0, aircon1, fan0, fan1}), 32'd0);
        check("t6_clear_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("t6_idle_in_ready", 32'(in_ready), 32'd1);
`endif

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
